// File: rtl/tdc_pkg.sv
// Shared types for the TDC timestamp capture path: timestamp word layout and capture FSM states.
package tdc_pkg;
    localparam int DEF_COARSE_W = 32;
    localparam int DEF_FINE_W   = 8;

    typedef struct packed {
        logic [DEF_COARSE_W-1:0] coarse;
        logic [DEF_FINE_W-1:0]   fine;
    } ts_word_t;

    typedef enum logic {IDLE, DEAD} cap_state_t;

    // Dead counter only has to hold DEAD_CYCLES-1; keep at least one bit.
    function automatic int dead_cnt_w(input int dead);
        return (dead > 1) ? $clog2(dead) : 1;
    endfunction
endpackage

// File: rtl/tdc_ts_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on dout as soon as it is written.
module tdc_ts_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; dout is forced to zero whenever nothing is queued.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/tdc_timestamp_capture.sv
// Hit timestamp capture with dead time and FWFT buffering.
// Optional TDC_DROP_COUNTER_EN adds a saturating 16-bit drop_count output.
module tdc_timestamp_capture
    import tdc_pkg::*;
#(
    parameter int COARSE_W    = DEF_COARSE_W,
    parameter int FINE_W      = DEF_FINE_W,
    parameter int DEPTH       = 16,
    parameter int DEAD_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [COARSE_W-1:0]        coarse_count,
    input  logic                       hit_valid,
    input  logic [FINE_W-1:0]          fine_code,
    output logic [COARSE_W+FINE_W-1:0] ts_data,
    output logic                       ts_valid,
    input  logic                       ts_ready,
    output logic                       fifo_full,
    output logic                       drop_pulse
`ifdef TDC_DROP_COUNTER_EN
    ,
    output logic [15:0]                drop_count
`endif
);
    localparam int DW = dead_cnt_w(DEAD_CYCLES);
    localparam logic [DW-1:0] DEAD_LOAD = (DEAD_CYCLES > 0) ? DW'(DEAD_CYCLES - 1) : '0;

    cap_state_t    state_q, state_d;
    logic [DW-1:0] dead_q, dead_d;
    logic          drop_q, drop_d;
    logic          hit_acc, push, pop, empty, full;

    assign hit_acc = hit_valid && (state_q == IDLE);
    assign pop     = ts_valid && ts_ready;
    assign push    = hit_acc && (!full || pop);
    assign drop_d  = hit_acc && !push;

    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
        case (state_q)
            IDLE: begin
                // Dropped hits still open a dead window.
                if (hit_acc && DEAD_CYCLES > 0) begin
                    state_d = DEAD;
                    dead_d  = DEAD_LOAD;
                end
            end
            DEAD: begin
                if (dead_q == '0) state_d = IDLE;
                else              dead_d  = dead_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dead_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dead_q  <= dead_d;
            drop_q  <= drop_d;
        end
    end

    tdc_ts_fifo #(
        .WIDTH (COARSE_W + FINE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({coarse_count, fine_code}),
        .dout  (ts_data),
        .empty (empty),
        .full  (full)
    );

    assign ts_valid   = !empty;
    assign fifo_full  = full;
    assign drop_pulse = drop_q;

`ifdef TDC_DROP_COUNTER_EN
    logic [15:0] drop_cnt_q;

    // Counts on the same edge that raises drop_pulse so the two line up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                drop_cnt_q <= '0;
        else if (drop_d && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 1'b1;
    end

    assign drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_tdc_timestamp_capture.sv
// Directed bench: u4 runs with 4 dead cycles, u0 with dead time disabled; both share stimulus.
module tb_tdc_timestamp_capture;
    import tdc_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] coarse = '0;
    logic [7:0]  fine = '0;
    logic        hit = 1'b0;
    logic        rdy = 1'b0;
    logic [39:0] d4, d0;
    logic        v4, v0, f4, f0, p4, p0;
`ifdef TDC_DROP_COUNTER_EN
    logic [15:0] dc4, dc0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tdc_timestamp_capture #(.DEPTH(16), .DEAD_CYCLES(4)) u4 (
        .clk(clk), .reset(reset), .coarse_count(coarse), .hit_valid(hit), .fine_code(fine),
        .ts_data(d4), .ts_valid(v4), .ts_ready(rdy), .fifo_full(f4), .drop_pulse(p4)
`ifdef TDC_DROP_COUNTER_EN
        , .drop_count(dc4)
`endif
    );

    tdc_timestamp_capture #(.DEPTH(16), .DEAD_CYCLES(0)) u0 (
        .clk(clk), .reset(reset), .coarse_count(coarse), .hit_valid(hit), .fine_code(fine),
        .ts_data(d0), .ts_valid(v0), .ts_ready(rdy), .fifo_full(f0), .drop_pulse(p0)
`ifdef TDC_DROP_COUNTER_EN
        , .drop_count(dc0)
`endif
    );

    typedef struct {
        logic        hit;
        logic [31:0] c;
        logic [7:0]  f;
        logic        rdy;
        logic        v;
        logic [39:0] d;
        logic        drop;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [39:0] w(input logic [31:0] c, input logic [7:0] f);
        ts_word_t t;
        t.coarse = c;
        t.fine   = f;
        return t;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic h, input logic [31:0] c, input logic [7:0] f, input logic r);
        hit = h; coarse = c; fine = f; rdy = r;
    endtask

    task automatic do_reset;
        set_in(1'b0, '0, '0, 1'b0);
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h100, 8'h3C, 1'b0, 1'b1, w(32'h100, 8'h3C), 1'b0};
        tbl[1]  = '{1'b0, 32'h0,   8'h00, 1'b1, 1'b0, 40'h0,             1'b0};
        tbl[2]  = '{1'b0, 32'h0,   8'h00, 1'b1, 1'b0, 40'h0,             1'b0};
        tbl[3]  = '{1'b0, 32'h0,   8'h00, 1'b1, 1'b0, 40'h0,             1'b0};
        tbl[4]  = '{1'b0, 32'h0,   8'h00, 1'b1, 1'b0, 40'h0,             1'b0};
        tbl[5]  = '{1'b1, 32'd10,  8'h01, 1'b1, 1'b1, w(32'd10, 8'h01),  1'b0};
        tbl[6]  = '{1'b1, 32'd11,  8'h00, 1'b1, 1'b0, 40'h0,             1'b0};
        tbl[7]  = '{1'b1, 32'd12,  8'h00, 1'b1, 1'b0, 40'h0,             1'b0};
        tbl[8]  = '{1'b1, 32'd13,  8'h00, 1'b1, 1'b0, 40'h0,             1'b0};
        tbl[9]  = '{1'b1, 32'd14,  8'h00, 1'b1, 1'b0, 40'h0,             1'b0};
        tbl[10] = '{1'b1, 32'd15,  8'h02, 1'b1, 1'b1, w(32'd15, 8'h02),  1'b0};
        tbl[11] = '{1'b0, 32'h0,   8'h00, 1'b1, 1'b0, 40'h0,             1'b0};

        // Reset state, before any clock edge
        #2;
        chk("rst valid", 64'(v4), 64'd0);
        chk("rst data",  64'(d4), 64'd0);
        chk("rst full",  64'(f4), 64'd0);
        chk("rst drop",  64'(p4), 64'd0);
        chk("rst valid0", 64'(v0), 64'd0);
`ifdef TDC_DROP_COUNTER_EN
        chk("rst drop_count", 64'(dc4), 64'd0);
`endif
        tick;
        tick;
        reset = 1'b0;

        // First capture latency and dead-time window
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].hit, tbl[i].c, tbl[i].f, tbl[i].rdy);
            tick;
            chk($sformatf("dead[%0d] valid", i), 64'(v4), 64'(tbl[i].v));
            chk($sformatf("dead[%0d] data", i),  64'(d4), 64'(tbl[i].d));
            chk($sformatf("dead[%0d] drop", i),  64'(p4), 64'(tbl[i].drop));
        end

        // Overflow: 17 back-to-back hits with no readout
        do_reset;
        for (int i = 0; i < 17; i++) begin
            set_in(1'b1, 32'h200 + 32'(i), 8'(i), 1'b0);
            tick;
            if (i < 16) begin
                chk($sformatf("ovf[%0d] full", i), 64'(f0), 64'(i == 15));
                chk($sformatf("ovf[%0d] head", i), 64'(d0), 64'(w(32'h200, 8'h00)));
                chk($sformatf("ovf[%0d] drop", i), 64'(p0), 64'd0);
            end else begin
                chk("ovf drop pulse", 64'(p0), 64'd1);
                chk("ovf full held",  64'(f0), 64'd1);
`ifdef TDC_DROP_COUNTER_EN
                chk("ovf drop_count", 64'(dc0), 64'd1);
`endif
            end
        end
        set_in(1'b0, '0, '0, 1'b0);
        tick;
        chk("ovf pulse ends", 64'(p0), 64'd0);
        rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain[%0d] valid", k), 64'(v0), 64'd1);
            chk($sformatf("drain[%0d] data", k),  64'(d0), 64'(w(32'h200 + 32'(k), 8'(k))));
            tick;
        end
        chk("drain empty", 64'(v0), 64'd0);
        chk("drain not full", 64'(f0), 64'd0);
`ifdef TDC_DROP_COUNTER_EN
        chk("drop_count held", 64'(dc0), 64'd1);
`endif

        // Full FIFO with simultaneous push and pop
        do_reset;
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, 32'h200 + 32'(i), 8'(i), 1'b0);
            tick;
        end
        chk("pp full before", 64'(f0), 64'd1);
        set_in(1'b1, 32'h300, 8'hAA, 1'b1);
        chk("pp head before", 64'(d0), 64'(w(32'h200, 8'h00)));
        tick;
        chk("pp full after", 64'(f0), 64'd1);
        chk("pp no drop",    64'(p0), 64'd0);
        set_in(1'b0, '0, '0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("pp[%0d] data", k), 64'(d0),
                64'((k < 16) ? w(32'h200 + 32'(k), 8'(k)) : w(32'h300, 8'hAA)));
            tick;
        end
        chk("pp empty", 64'(v0), 64'd0);

        // Coarse wrap passes through untouched
        do_reset;
        set_in(1'b1, 32'hFFFF_FFFE, 8'h11, 1'b0);
        tick;
        hit = 1'b0;
        repeat (4) tick;
        set_in(1'b1, 32'h0000_0003, 8'h22, 1'b0);
        tick;
        hit = 1'b0;
        chk("wrap first",  64'(d4), 64'(w(32'hFFFF_FFFE, 8'h11)));
        rdy = 1'b1;
        tick;
        chk("wrap second valid", 64'(v4), 64'd1);
        chk("wrap second", 64'(d4), 64'(w(32'h0000_0003, 8'h22)));
        tick;
        chk("wrap empty", 64'(v4), 64'd0);

        // Async reset with entries queued and FSM in DEAD
        do_reset;
        for (int j = 0; j < 5; j++) begin
            set_in(1'b1, 32'h400 + 32'(j), 8'(j), 1'b0);
            tick;
            hit = 1'b0;
            if (j < 4) repeat (4) tick;
        end
        chk("mid queued", 64'(d4), 64'(w(32'h400, 8'h00)));
        #2;
        reset = 1'b1;
        #1;
        chk("async valid", 64'(v4), 64'd0);
        chk("async data",  64'(d4), 64'd0);
        tick;
        tick;
        reset = 1'b0;
        set_in(1'b1, 32'h500, 8'h55, 1'b0);
        tick;
        chk("post-rst accept valid", 64'(v4), 64'd1);
        chk("post-rst accept data",  64'(d4), 64'(w(32'h500, 8'h55)));
        set_in(1'b0, '0, '0, 1'b1);
        tick;
        chk("post-rst single entry", 64'(v4), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tdc_timestamp_capture.md
Name: tdc_timestamp_capture

Overview:
- Downstream consumer of the free-running 32-bit coarse counter in the TDC datapath.
- On each hit strobe from the fine-interpolator front end, the block:
  - samples the coarse count,
  - concatenates the fine code,
  - applies a programmable dead time,
  - buffers the timestamp in a first-word-fall-through FIFO.
- Timestamps leave via a valid/ready stream to the readout/packetizer stage.

Parameters:
- COARSE_W, 32, coarse count width; matches the main counter output.
- FINE_W, 8, fine-interpolator code width.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- DEAD_CYCLES, 4, cycles after an accepted hit during which further hits are ignored; 0 disables dead time.

Ports:
- clk  in  1  system clock; same clock as the coarse counter.
- reset  in  1  asynchronous, active-high reset.
- coarse_count  in  COARSE_W  coarse time from the main counter.
- hit_valid  in  1  single-cycle strobe: a hit occurred this cycle.
- fine_code  in  FINE_W  fine code qualified by hit_valid.
- ts_data  out  COARSE_W+FINE_W  timestamp {coarse, fine}; coarse in the MSBs.
- ts_valid  out  1  ts_data holds a valid entry.
- ts_ready  in  1  downstream accepts the current entry.
- fifo_full  out  1  FIFO holds DEPTH entries.
- drop_pulse  out  1  one-cycle pulse: a hit was lost to overflow.

Behaviour:
- Reset (async assert, sync release):
  - ts_valid=0, ts_data=0, fifo_full=0, drop_pulse=0.
  - FIFO pointers and count = 0; FSM to IDLE; dead counter = 0.
  - Any in-flight entries are discarded.
- Capture:
  - On a rising clk edge with hit_valid=1 and FSM in IDLE, the word {coarse_count, fine_code} sampled at that edge is "accepted".
  - No arithmetic correction is applied; coarse_count is used exactly as presented.
- FSM states: IDLE and DEAD.
  - IDLE + accepted hit with DEAD_CYCLES>0: go to DEAD and load the dead counter with DEAD_CYCLES-1.
  - DEAD: hit_valid is ignored. No push, no drop_pulse.
  - DEAD: the counter decrements each cycle; at 0 the FSM returns to IDLE on the next edge.
  - Result: the next hit can be accepted exactly DEAD_CYCLES+1 cycles after the previous one.
  - DEAD_CYCLES=0: the FSM stays in IDLE, and a hit can be accepted every cycle.
- Push:
  - An accepted hit is written to the FIFO if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the hit is dropped: drop_pulse=1 on the following cycle and the FIFO is unchanged.
  - A dropped hit still starts dead time.
- Pop: occurs when ts_valid && ts_ready.
  - The next entry (or none) is presented the following cycle.
  - ts_data is held stable while ts_valid=1 and ts_ready=0.
- Latency and output rules:
  - Hit accepted into an empty FIFO at edge N gives ts_valid=1 with that word from after edge N. This is the first-word-fall-through output register.
  - Simultaneous push and pop on an empty FIFO is impossible, because ts_valid=0 when the FIFO is empty.
  - ts_valid is never asserted when the FIFO count is 0.
- Occupancy:
  - Count range is 0..DEPTH; fifo_full = (count==DEPTH).
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Push+pop in the same cycle leaves the count unchanged.
- Coarse wrap: coarse_count rolling from 0xFFFFFFFF to 0 is passed through unmodified; the downstream stage handles unwrapping.

Optional Feature:
- Macro: TDC_DROP_COUNTER_EN.
- Defined:
  - Adds output port drop_count, 16 bits, reset to 0.
  - drop_count increments on every drop_pulse.
  - It saturates at 0xFFFF and does not wrap.
  - Cleared only by reset.
- Undefined: the port and the counter are absent; drop_pulse behaviour is unchanged.

Decomposition:
- Package tdc_pkg:
  - COARSE_W and FINE_W defaults.
  - typedef ts_word_t as a packed struct {coarse, fine}.
  - Capture FSM enum, cap_state_t, with values IDLE and DEAD.
- One sub-module, tdc_ts_fifo:
  - Parameterized first-word-fall-through FIFO (width, DEPTH).
  - Ports: push, pop, din, dout, empty, full, with async active-high reset.
  - The top level holds the FSM, dead counter, drop logic and optional counter.

Test Plan:
- Reset, then hit_valid at coarse_count=0x00000100 with fine_code=0x3C (DEAD_CYCLES=4) -> ts_valid=1 on the next cycle, ts_data=0x000001003C.
- Hits on consecutive cycles from coarse=10, ts_ready=1 -> only the hit at 10 is accepted; hits at 11..14 are ignored with no drop_pulse; the hit at 15 is accepted.
- ts_ready=0, DEAD_CYCLES=0, 17 hits with DEPTH=16 -> fifo_full=1 after the 16th; the 17th gives one drop_pulse (drop_count=1 if TDC_DROP_COUNTER_EN); entries then drain in order.
- FIFO full with ts_ready=1 and a hit in the same cycle -> push accepted, no drop, count stays 16, output order preserved.
- Hits at coarse=0xFFFFFFFE and then at coarse=0x00000003 -> both words are output verbatim with no alteration at the wrap.
- Reset asserted mid-stream with 5 entries queued and the FSM in DEAD -> ts_valid=0 immediately (async); after release the FIFO is empty, the FSM is in IDLE, and a hit on the first cycle after release is accepted.
